// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock byte FIFO with full/empty status.
// Ports: clk, reset (async low), write_en, read_en, data_in, data_out, full, empty.
module sync_fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_acc;
  logic                  wr_acc;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A concurrent read frees the slot a full FIFO would otherwise refuse.
  assign rd_acc = read_en && !empty;
  assign wr_acc = write_en && (!full || rd_acc);

  // Array is not reset; holding off writes during reset keeps it untouched.
  always_ff @(posedge clk) begin
    if (wr_acc && reset) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      unique case (1'b1)
        (wr_acc && !rd_acc): count <= count + 1'b1;
        (rd_acc && !wr_acc): count <= count - 1'b1;
        default:             count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_core.sv
// tb_sync_fifo_core: directed checks of sync_fifo_core.
// Fill, overflow, drain, wrap, concurrency and mid-op reset.
module tb_sync_fifo_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_run = 0;
  int n_fail = 0;

  sync_fifo_core dut (
    .clk(clk),
    .reset(reset),
    .write_en(write_en),
    .read_en(read_en),
    .data_in(data_in),
    .data_out(data_out),
    .full(full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given request; inputs drop again after the edge.
  task automatic step(input logic we, input logic re, input logic [7:0] d);
    @(negedge clk);
    write_en = we;
    read_en  = re;
    data_in  = d;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 0) chk("fill_empty0", empty, 0);
      if (i == 6) chk("fill_full7", full, 0);
    end
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);

    step(1'b1, 1'b0, 8'd99);
    chk("ovf_full", full, 1);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'd0);
      chk($sformatf("drain_%0d", i), data_out, i);
      if (i == 0) chk("drain_full", full, 0);
      if (i == 6) chk("drain_empty7", empty, 0);
    end
    chk("drain_empty", empty, 1);
    step(1'b0, 1'b1, 8'd0);
    chk("under_dout", data_out, 7);
    chk("under_empty", empty, 1);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(30 + i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'd0);
    chk("wrap_rd3", data_out, 33);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(40 + i));
    chk("wrap_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'd0);
      chk($sformatf("wrap_%0d", i), data_out, (i < 4) ? 34 + i : 36 + i);
    end
    chk("wrap_empty", empty, 1);

    step(1'b1, 1'b0, 8'd50);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 8'(60 + k));
      chk($sformatf("both_dout%0d", k), data_out, (k == 0) ? 50 : 59 + k);
      chk($sformatf("both_empty%0d", k), empty, 0);
    end
    step(1'b0, 1'b1, 8'd0);
    chk("both_last", data_out, 64);
    chk("both_empty", empty, 1);

    step(1'b1, 1'b1, 8'd77);
    chk("emp_both_dout", data_out, 64);
    chk("emp_both_empty", empty, 0);
    step(1'b0, 1'b1, 8'd0);
    chk("emp_both_rd", data_out, 77);
    chk("emp_both_e", empty, 1);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(80 + i));
    step(1'b1, 1'b1, 8'd88);
    chk("full_both_dout", data_out, 80);
    chk("full_both_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'd0);
      chk($sformatf("full_both_%0d", i), data_out, 81 + i);
    end
    chk("full_both_empty", empty, 1);

    step(1'b1, 1'b0, 8'd55);
    chk("mid_pre_empty", empty, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_empty", empty, 1);
    chk("mid_full", full, 0);
    chk("mid_dout", data_out, 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 8'd0);
    chk("mid_rd_dout", data_out, 0);
    chk("mid_rd_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
